wing_motion_ctrl: RTL and testbench

Per-frame motion and animation controller for the bird sprite. Produces `wing_height`, `wing_angle`, `wing_state` and `wing_valid`, the inputs consumed by the wing sprite renderer. Integrates a simple gravity/flap physics model once per video frame and maps vertical velocity to a tilt angle. Sits between the game-control logic (buttons, collision, restart) and the sprite renderer.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/wing_angle_map.sv | 25 ++
 rtl/wing_motion_ctrl.sv | 165 ++++++++++++++++
 tb/tb_wing_motion_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the bird sprite motion and render path.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_FALL = 2'd2,
    ST_DEAD = 2'd3
  } wing_st_e;

  localparam int SPRITE_H = 32;
  localparam int SCREEN_H = 480;
  localparam int VEL_W    = 8;

  localparam logic [3:0] ANG_IDLE = 4'd2;
  localparam logic [3:0] ANG_DEAD = 4'd10;

endpackage

// File: rtl/wing_angle_map.sv
// Signed vertical velocity to 4-bit tilt index, 0 nose up to 10 nose down.
module wing_angle_map
  import flappy_pkg::*;
(
  input  logic signed [VEL_W-1:0] vel_i,
  output logic [3:0]              angle_o
);

  always_comb begin
    angle_o = ANG_DEAD;
    unique case (1'b1)
      (vel_i <= VEL_W'(-4)):
        angle_o = 4'd0;
      (vel_i >= VEL_W'(-3)) && (vel_i <= VEL_W'(-1)):
        angle_o = 4'd1;
      (vel_i >= VEL_W'(0)) && (vel_i <= VEL_W'(1)):
        angle_o = 4'd2;
      (vel_i >= VEL_W'(2)) && (vel_i <= VEL_W'(8)):
        angle_o = vel_i[3:0] + 4'd1;
      default:
        angle_o = ANG_DEAD;
    endcase
  end

endmodule

// File: rtl/wing_motion_ctrl.sv
// Per-frame flap/gravity physics, tilt and wing animation for the bird sprite.
module wing_motion_ctrl
  import flappy_pkg::*;
#(
  parameter logic [8:0] START_H  = 9'd200,
  parameter logic [8:0] GROUND_Y = 9'd400,
  parameter int         FLAP_V   = -6,
  parameter int         MAX_V    = 8,
  parameter int         GRAV_DIV = 2,
  parameter int         ANIM_DIV = 4
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap_btn,
  input  logic       game_over,
  input  logic       game_restart,
  output logic [8:0] wing_height,
  output logic [3:0] wing_angle,
  output logic [2:0] wing_state,
  output logic       wing_valid,
  output logic       hit_ground
);

  localparam logic [8:0] MAX_H = GROUND_Y - 9'(SPRITE_H);
  localparam logic signed [VEL_W-1:0] V_FLAP = VEL_W'(FLAP_V);
  localparam logic signed [VEL_W-1:0] V_MAX  = VEL_W'(MAX_V);
  localparam logic [7:0] GRAV_LAST = 8'(GRAV_DIV - 1);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  wing_st_e st_q, st_d;
  logic [8:0] h_q, h_d;
  logic signed [VEL_W-1:0] v_q, v_d;
  logic [7:0] grav_q, grav_d;
  logic [7:0] anim_q, anim_d;
  logic [2:0] ws_q, ws_d;
  logic [3:0] ang_q, ang_d;
  logic pend_q, pend_d;
  logic btn_q, valid_q;
  logic hit_q, hit_d;
  logic rise, run, flap_use;
  logic signed [10:0] h_sum;
  logic [3:0] map_ang;

  wing_angle_map u_map (
    .vel_i   (v_d),
    .angle_o (map_ang)
  );

  assign rise = flap_btn & ~btn_q;

  always_comb begin
    st_d   = st_q;
    h_d    = h_q;
    v_d    = v_q;
    grav_d = grav_q;
    anim_d = anim_q;
    ws_d   = ws_q;
    hit_d  = 1'b0;
    h_sum  = '0;
    // a tick consumes the old flap; an edge on that same cycle waits a frame
    pend_d = frame_tick ? rise : (pend_q | rise);
    flap_use = pend_q &
      ((st_q == ST_IDLE) | ((st_q == ST_FLY) & ~game_over));
    run = frame_tick & ((st_q == ST_FLY) | (st_q == ST_FALL) |
      ((st_q == ST_IDLE) & pend_q));

    if ((st_q == ST_FLY) && game_over) st_d = ST_FALL;

    if (frame_tick && ((st_q == ST_IDLE) || (st_q == ST_FLY))) begin
      if (anim_q == ANIM_LAST) begin
        anim_d = '0;
        ws_d   = (ws_q == 3'd2) ? 3'd0 : ws_q + 3'd1;
      end else begin
        anim_d = anim_q + 8'd1;
      end
    end

    if (run) begin
      if (flap_use) begin
        v_d    = V_FLAP;
        grav_d = '0;
      end else if (grav_q == GRAV_LAST) begin
        grav_d = '0;
        if (v_q < V_MAX) v_d = v_q + VEL_W'(1);
      end else begin
        grav_d = grav_q + 8'd1;
      end
      h_sum = $signed({2'b00, h_q}) +
        $signed({{(11-VEL_W){v_d[VEL_W-1]}}, v_d});
      if (h_sum < 0)
        h_d = '0;
      else if (h_sum > $signed({2'b00, MAX_H}))
        h_d = MAX_H;
      else
        h_d = h_sum[8:0];
      if (st_q == ST_IDLE) st_d = ST_FLY;
      if (h_d == MAX_H) begin
        st_d  = ST_DEAD;
        hit_d = 1'b1;
      end
    end

    if ((st_d == ST_FALL) || (st_d == ST_DEAD)) begin
      pend_d = 1'b0;
      anim_d = '0;
      ws_d   = '0;
    end

    if (game_restart) begin
      st_d   = ST_IDLE;
      h_d    = START_H;
      v_d    = '0;
      grav_d = '0;
      anim_d = '0;
      ws_d   = '0;
      pend_d = 1'b0;
      hit_d  = 1'b0;
    end
  end

  always_comb begin
    ang_d = map_ang;
    unique case (1'b1)
      (st_d == ST_IDLE): ang_d = ANG_IDLE;
      (st_d == ST_DEAD): ang_d = ANG_DEAD;
      default:           ang_d = map_ang;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      h_q     <= START_H;
      v_q     <= '0;
      grav_q  <= '0;
      anim_q  <= '0;
      ws_q    <= '0;
      ang_q   <= ANG_IDLE;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      h_q     <= h_d;
      v_q     <= v_d;
      grav_q  <= grav_d;
      anim_q  <= anim_d;
      ws_q    <= ws_d;
      ang_q   <= ang_d;
      pend_q  <= pend_d;
      btn_q   <= flap_btn;
      valid_q <= 1'b1;
      hit_q   <= hit_d;
    end
  end

  assign wing_height = h_q;
  assign wing_angle  = ang_q;
  assign wing_state  = ws_q;
  assign wing_valid  = valid_q;
  assign hit_ground  = hit_q;

endmodule

// File: tb/tb_wing_motion_ctrl.sv
// Bench for wing_motion_ctrl: table vectors, reference model and scoreboard.
module tb_wing_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       flap_btn = 1'b0;
  logic       game_over = 1'b0;
  logic       game_restart = 1'b0;
  logic [8:0] wing_height;
  logic [3:0] wing_angle;
  logic [2:0] wing_state;
  logic       wing_valid;
  logic       hit_ground;

  wing_motion_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .flap_btn     (flap_btn),
    .game_over    (game_over),
    .game_restart (game_restart),
    .wing_height  (wing_height),
    .wing_angle   (wing_angle),
    .wing_state   (wing_state),
    .wing_valid   (wing_valid),
    .hit_ground   (hit_ground)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int a;
    int ws;
    int v;
    int hit;
  } exp_t;

  typedef struct {
    bit   tk;
    bit   fl;
    bit   go;
    bit   rs;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model; states 0 idle, 1 fly, 2 fall, 3 dead
  int m_st, m_h, m_v, m_g, m_a, m_ws, m_hit, m_valid;
  bit m_pend, m_prev;

  function automatic int ref_ang(int st, int v);
    if (st == 0) return 2;
    if (st == 3) return 10;
    if (v <= -4) return 0;
    if (v < 0) return 1;
    if (v < 2) return 2;
    if (v + 1 > 10) return 10;
    return v + 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 200; m_v = 0; m_g = 0; m_a = 0; m_ws = 0;
    m_pend = 0; m_prev = 0; m_hit = 0; m_valid = 0;
  endtask

  task automatic model_cyc(input bit tk, fl, go, rs, rn);
    bit rise;
    bit use_flap;
    int nh;
    if (!rn) begin
      model_reset();
      return;
    end
    rise = fl && !m_prev;
    m_prev = fl;
    m_hit = 0;
    m_valid = 1;
    if (rs) begin
      m_st = 0; m_h = 200; m_v = 0; m_g = 0; m_a = 0; m_ws = 0;
      m_pend = 0;
      return;
    end
    if (m_st == 1 && go) m_st = 2;
    if (tk) begin
      if (m_st == 0 || m_st == 1) begin
        m_a++;
        if (m_a == 4) begin
          m_a = 0;
          m_ws = (m_ws + 1) % 3;
        end
      end
      if (m_st == 1 || m_st == 2 || (m_st == 0 && m_pend)) begin
        use_flap = m_pend && m_st != 2;
        if (use_flap) begin
          m_v = -6;
          m_g = 0;
        end else begin
          m_g++;
          if (m_g == 2) begin
            m_g = 0;
            if (m_v < 8) m_v++;
          end
        end
        nh = m_h + m_v;
        if (nh < 0) nh = 0;
        if (nh > 368) nh = 368;
        m_h = nh;
        if (m_st == 0) m_st = 1;
        if (m_h == 368) begin
          m_st = 3;
          m_hit = 1;
        end
      end
      m_pend = rise;
    end else if (rise) begin
      m_pend = 1;
    end
    if (m_st == 2 || m_st == 3) begin
      m_pend = 0;
      m_a = 0;
      m_ws = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one clock: drive at negedge, push expectation, compare at next negedge
  task automatic drive(input bit tk, fl, go, rs, rn,
                       input bit use_tab, input exp_t te, input string nm);
    exp_t e;
    frame_tick = tk;
    flap_btn = fl;
    game_over = go;
    game_restart = rs;
    rst_n = rn;
    model_cyc(tk, fl, go, rs, rn);
    if (use_tab) e = te;
    else e = '{m_h, ref_ang(m_st, m_v), m_ws, m_valid, m_hit};
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk({nm, "_queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_h"}, int'(wing_height), e.h);
      chk({nm, "_ang"}, int'(wing_angle), e.a);
      chk({nm, "_ws"}, int'(wing_state), e.ws);
      chk({nm, "_valid"}, int'(wing_valid), e.v);
      chk({nm, "_hit"}, int'(hit_ground), e.hit);
    end
  endtask

  task automatic cyc(input bit tk, fl, go, rs, input string nm);
    exp_t z;
    z = '{0, 0, 0, 0, 0};
    drive(tk, fl, go, rs, 1'b1, 1'b0, z, nm);
  endtask

  vec_t tv[10];
  exp_t z0;
  int hits;
  int last_ang;
  int wraps;

  initial begin
    z0 = '{0, 0, 0, 0, 0};
    model_reset();
    tv[0] = '{0, 0, 0, 0, '{200, 2, 0, 1, 0}};
    tv[1] = '{1, 0, 0, 0, '{200, 2, 0, 1, 0}};
    tv[2] = '{0, 0, 0, 0, '{200, 2, 0, 1, 0}};
    tv[3] = '{1, 0, 0, 0, '{200, 2, 0, 1, 0}};
    tv[4] = '{1, 0, 0, 0, '{200, 2, 0, 1, 0}};
    tv[5] = '{1, 0, 0, 0, '{200, 2, 1, 1, 0}};
    tv[6] = '{0, 0, 0, 0, '{200, 2, 1, 1, 0}};
    tv[7] = '{0, 1, 0, 0, '{200, 2, 1, 1, 0}};
    tv[8] = '{1, 1, 0, 0, '{194, 0, 1, 1, 0}};
    tv[9] = '{0, 0, 0, 0, '{194, 0, 1, 1, 0}};

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1'b1, '{200, 2, 0, 0, 0}, "reset0");
    drive(0, 0, 0, 0, 0, 1'b1, '{200, 2, 0, 0, 0}, "reset1");

    for (int i = 0; i < 10; i++)
      drive(tv[i].tk, tv[i].fl, tv[i].go, tv[i].rs, 1'b1, 1'b1,
            tv[i].e, $sformatf("tv%0d", i));

    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, "rise");
    chk("apex_h", int'(wing_height), 158);
    chk("apex_ang", int'(wing_angle), 2);
    chk("apex_ws", int'(wing_state), 1);

    hits = 0;
    last_ang = -1;
    for (int i = 0; i < 100 && m_st != 3; i++) begin
      cyc(1, 0, 0, 0, "drop");
      if (hit_ground) hits++;
      else last_ang = int'(wing_angle);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(i == 1, 0, 0, 0, "dead");
      if (hit_ground) hits++;
    end
    chk("hit_once", hits, 1);
    chk("pre_dead_ang", last_ang, 9);
    chk("ground_h", int'(wing_height), 368);
    chk("dead_ang", int'(wing_angle), 10);

    cyc(0, 0, 0, 1, "restart");
    chk("restart_h", int'(wing_height), 200);
    chk("restart_ang", int'(wing_angle), 2);

    cyc(0, 1, 0, 0, "f4press");
    cyc(1, 1, 0, 0, "f4tick");
    cyc(0, 0, 0, 0, "f4rel");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, "f4up");
    chk("pre_go_h", int'(wing_height), 174);
    cyc(0, 1, 0, 0, "go_press");
    cyc(0, 1, 1, 0, "go_pulse");
    cyc(0, 0, 0, 0, "go_rel");
    chk("fall_ws", int'(wing_state), 0);
    cyc(1, 0, 0, 0, "fall_t1");
    chk("fall_h1", int'(wing_height), 170);
    chk("fall_ang1", int'(wing_angle), 0);
    cyc(0, 1, 0, 0, "fall_press");
    cyc(1, 1, 0, 0, "fall_t2");
    chk("fall_h2", int'(wing_height), 167);
    chk("fall_ws2", int'(wing_state), 0);
    cyc(0, 0, 0, 0, "fall_rel");
    for (int i = 0; i < 100 && m_st != 3; i++) cyc(1, 0, 0, 0, "fall_dn");
    chk("fall_dead_h", int'(wing_height), 368);

    cyc(0, 0, 0, 1, "restart2");
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 0, 0, "cl_press");
      cyc(1, 1, 0, 0, "cl_tick");
      if (wing_height > 9'd200) wraps++;
      cyc(0, 0, 0, 0, "cl_rel");
    end
    chk("ceil_h", int'(wing_height), 0);
    chk("ceil_nowrap", wraps, 0);
    chk("ceil_ang", int'(wing_angle), 0);

    cyc(1, 0, 0, 0, "pre_rst");
    drive(0, 1, 0, 0, 0, 1'b1, '{200, 2, 0, 0, 0}, "midrst");
    cyc(0, 0, 0, 0, "post_rst");
    chk("post_rst_valid", int'(wing_valid), 1);
    chk("post_rst_h", int'(wing_height), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
